// File: rtl/tdm_demux16_8b_if.sv
// Bus bundle between a TDM sample source and the tdm_demux16_8b receiver.
// The source drives samples and frame sync; the receiver returns the rebuilt frame and link status.
interface tdm_demux16_8b_if #(
    parameter int W = 8,
    parameter int N = 16
);
    logic [W-1:0]   din;
    logic           din_valid;
    logic           sync;
    logic [N*W-1:0] dout;
    logic           frame_valid;
    logic [3:0]     slot;
    logic           locked;
    logic           sync_err;

    modport master (
        output din, din_valid, sync,
        input  dout, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, sync,
        output dout, frame_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux16_8b.sv
// Receive end of a 16-slot TDM link: follows the slot number from the frame-sync marker,
// rebuilds the channel words, and publishes each complete frame in one step.
module tdm_demux16_8b #(
    parameter int W = 8,
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    tdm_demux16_8b_if.slave  bus
);
    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [3:0] SLOT_LAST = 4'(N - 1);

    logic [0:0]           state_q, state_d;
    logic [3:0]           slot_q, slot_d;
    logic [(N-1)*W-1:0]   shadow_q, shadow_d;
    logic [N*W-1:0]       dout_q, dout_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_err_q, sync_err_d;
    logic                 accept;

    assign accept = en & bus.din_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (accept) begin
            if (state_q == ST_HUNT) begin
                if (bus.sync) begin
                    shadow_d[0 +: W] = bus.din;
                    slot_d           = 4'd1;
                    state_d          = ST_LOCKED;
                end
            end else if (bus.sync) begin
                // A sync away from slot 0 restarts the frame on this sample.
                sync_err_d       = (slot_q != 4'd0);
                shadow_d[0 +: W] = bus.din;
                slot_d           = 4'd1;
            end else if (slot_q == 4'd0) begin
                sync_err_d = 1'b1;
                state_d    = ST_HUNT;
                slot_d     = 4'd0;
            end else if (slot_q == SLOT_LAST) begin
                dout_d        = {bus.din, shadow_q};
                frame_valid_d = 1'b1;
                slot_d        = 4'd0;
            end else begin
                for (int k = 1; k < N - 1; k++) begin
                    if (slot_q == 4'(k)) shadow_d[k*W +: W] = bus.din;
                end
                slot_d = slot_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            slot_q        <= 4'd0;
            // NOTE: the shadow words sit in flops, so clearing them on reset is cheap and keeps them defined.
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.slot        = slot_q;
    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux16_8b.sv
// Scoreboard bench for tdm_demux16_8b: the driver pushes per-cycle expectations from an
// array-based frame model, and an independent monitor pops and compares after each clock edge.
module tb_tdm_demux16_8b;
    localparam int W = 8;
    localparam int N = 16;

    typedef struct packed {
        logic           fv;
        logic           err;
        logic           lk;
        logic [3:0]     sl;
        logic [N*W-1:0] dv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;

    tdm_demux16_8b_if #(.W(W), .N(N)) bus ();

    tdm_demux16_8b #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    // Reference model: link status plus plain arrays of channel words.
    bit       m_locked;
    int       m_slot;
    bit [7:0] m_shadow [16];
    bit [7:0] m_dout   [16];

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] model_dout();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_dout[k];
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_slot   = 0;
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = 8'h00;
            m_dout[k]   = 8'h00;
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic send(input bit e, input bit v, input bit s, input logic [7:0] d);
        exp_t x;
        @(negedge clk);
        en            = e;
        bus.din_valid = v;
        bus.sync      = s;
        bus.din       = d;
        x.fv  = 1'b0;
        x.err = 1'b0;
        if (e && v) begin
            if (!m_locked) begin
                if (s) begin
                    m_shadow[0] = d;
                    m_slot      = 1;
                    m_locked    = 1;
                end
            end else if (s) begin
                x.err       = (m_slot != 0);
                m_shadow[0] = d;
                m_slot      = 1;
            end else if (m_slot == 0) begin
                x.err    = 1'b1;
                m_locked = 0;
            end else begin
                m_shadow[m_slot] = d;
                if (m_slot == 15) begin
                    m_dout = m_shadow;
                    x.fv   = 1'b1;
                    m_slot = 0;
                end else begin
                    m_slot = m_slot + 1;
                end
            end
        end
        x.lk = m_locked;
        x.sl = 4'(m_slot);
        x.dv = model_dout();
        exp_q.push_back(x);
    endtask

    task automatic send_frame(input logic [7:0] base, input bit rnd);
        for (int k = 0; k < N; k++)
            send(1, 1, k == 0, rnd ? 8'($urandom) : base + 8'(k));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, bus.dout, '0);
        check({tag, "_frame_valid"}, {127'd0, bus.frame_valid}, '0);
        check({tag, "_sync_err"}, {127'd0, bus.sync_err}, '0);
        check({tag, "_locked"}, {127'd0, bus.locked}, '0);
        check({tag, "_slot"}, {124'd0, bus.slot}, '0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per driven cycle, compared just after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_valid", {127'd0, bus.frame_valid}, {127'd0, e.fv});
                check("sync_err", {127'd0, bus.sync_err}, {127'd0, e.err});
                check("locked", {127'd0, bus.locked}, {127'd0, e.lk});
                check("slot", {124'd0, bus.slot}, {124'd0, e.sl});
                check("dout", bus.dout, e.dv);
            end else begin
                check("idle_pulses", {126'd0, bus.frame_valid, bus.sync_err}, '0);
            end
        end
    end

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #3 check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back frame carrying the channel index.
        send_frame(8'h00, 0);

        // Fresh link: unsynced samples are dropped, then a good frame.
        do_reset("rst_pre_hunt");
        repeat (5) send(1, 1, 0, 8'hAA);
        send_frame(8'h10, 0);

        // Early sync after six samples restarts the frame on 0x55.
        send_frame(8'h00, 1);
        for (int k = 0; k < 6; k++) send(1, 1, k == 0, 8'($urandom));
        send(1, 1, 1, 8'h55);
        for (int k = 1; k < N; k++) send(1, 1, 0, 8'($urandom));

        // Slot-0 sample without sync drops the link.
        send(1, 1, 0, 8'h77);
        send(1, 1, 0, 8'h78);
        send_frame(8'h20, 0);

        // Gapped frame with a three-cycle enable drop in the middle.
        for (int k = 0; k < N; k++) begin
            send(1, 1, k == 0, 8'(k));
            send(1, 0, 1, 8'($urandom));
            if (k == 7) repeat (3) send(0, 1, 1'($urandom), 8'($urandom));
        end

        // Asynchronous reset mid-frame, then recovery.
        for (int k = 0; k < 9; k++) send(1, 1, k == 0, 8'($urandom));
        do_reset("rst_mid_frame");
        send_frame(8'h30, 0);

        // Randomized traffic with gaps, enable drops and occasional protocol errors.
        for (int i = 0; i < 600; i++) begin
            bit e, v, s;
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) != 0);
            if (m_slot == 0) s = ($urandom_range(0, 9) != 0);
            else             s = ($urandom_range(0, 39) == 0);
            send(e, v, s, 8'($urandom));
        end

        send(1, 0, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
